apb_lsu_bridge: RTL

- Converts single load/store requests from the core's load-store unit into APB-style transfers on the `pclk` bus that feeds the SRAM slave.
- On the request side it derives lane strobes from the access size. On the response side it sign- or zero-extends the low-aligned read data.
- It enforces one outstanding transfer and an idle gap between transfers, and optionally times out a hung slave.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_lsu_bridge_load_ext.sv | 20 ++
 rtl/apb_lsu_bridge.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared encodings for the LSU-to-APB bridge: access sizes, FSM states and lane strobes.
package apb_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [3:0] STB_B = 4'b0001;
  localparam logic [3:0] STB_H = 4'b0011;
  localparam logic [3:0] STB_W = 4'b1111;

  // Strobes stay low-aligned; the SRAM slave applies the byte offset itself.
  function automatic logic [3:0] size_to_stb(input logic [1:0] size);
    case (size)
      SIZE_B:  return STB_B;
      SIZE_H:  return STB_H;
      default: return STB_W;
    endcase
  endfunction

endpackage

// File: rtl/apb_lsu_bridge_load_ext.sv
// lsu_load_ext: sign/zero extension of low-aligned load data according to access size.
module lsu_load_ext
  import apb_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SIZE_B:  ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_H:  ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/apb_lsu_bridge.sv
// apb_lsu_bridge: single-outstanding LSU request to APB transfer bridge with load extension.
// Optional ACCESS-phase watchdog enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_lsu_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);

  logic [1:0]            state_reg;
  logic [1:0]            size_reg;
  logic                  unsigned_reg;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  timeout_hit;

  assign req_ready = (state_reg == ST_IDLE) && !prst;

  lsu_load_ext u_load_ext (
    .raw         (prdata),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .ext         (load_ext)
  );

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] timeout_cnt_reg;

  // Abort fires on the TIMEOUT-th ACCESS cycle that still has no pready.
  assign timeout_hit = (timeout_cnt_reg == CNT_LAST);

  always_ff @(posedge pclk) begin
    if (prst) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == ST_SETUP) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS && !pready) begin
      timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_reg    <= ST_IDLE;
      size_reg     <= SIZE_B;
      unsigned_reg <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pdata        <= '0;
      pstb         <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_size == SIZE_RSV) begin
              // Reserved size never reaches the bus; it is answered directly from IDLE.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              paddr        <= req_addr;
              pdata        <= req_wdata;
              pwrite       <= req_write;
              pstb         <= size_to_stb(req_size);
              size_reg     <= req_size;
              unsigned_reg <= req_unsigned;
              psel         <= 1'b1;
              penable      <= 1'b0;
              state_reg    <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable   <= 1'b1;
          state_reg <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready takes priority over a simultaneous timeout.
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            state_reg  <= ST_IDLE;
            resp_valid <= 1'b1;
            resp_err   <= perr;
            resp_rdata <= pwrite ? '0 : load_ext;
          end else if (timeout_hit) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            state_reg  <= ST_IDLE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
